// File: rtl/shift_rx_8.sv
`default_nettype none
//============================================================================
// Module   : shift_rx_8
// Purpose  : Serial-in / parallel-out receiver. Samples one bit per shift
//            strobe, starting a word on a framed strobe, assembles WIDTH bits
//            MSB-first or LSB-first and presents each completed word in a
//            valid/ready holding register with overrun and framing-error
//            reporting.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            s_in, shift    - serial bit and its sample strobe
//            frame          - strobed bit is bit 0 of a new word
//            msb_first      - bit order, latched at the start of each word
//            d_ready        - consumer accepts d_out while d_valid is high
//            ovr_clr        - clears the sticky overrun flag
//            d_out, d_valid - holding register and its valid flag
//            busy           - a word is being received
//            overrun        - sticky: completed word dropped (holding full)
//            frame_err      - one-cycle pulse: frame arrived mid-word
// Revision : 1.0 - initial release
//============================================================================
module shift_rx_8 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_in,
    input  logic             shift,
    input  logic             frame,
    input  logic             msb_first,
    input  logic             d_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] d_out,
    output logic             d_valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   sr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               dir_q;
    logic [WIDTH-1:0]   d_out_q;
    logic               d_valid_q;
    logic               overrun_q;
    logic               frame_err_q;

    logic               start_w;
    logic               take_w;
    logic               last_w;
    logic               dir_w;
    logic [WIDTH-1:0]   base_w;
    logic [WIDTH-1:0]   sr_d;

    always_comb begin
        // A framed strobe starts a new word in either state.
        start_w = shift & frame;
        take_w  = shift & ~frame & (state_q == S_RECV);
        last_w  = take_w & (cnt_q == CNT_W'(WIDTH - 1));
        // The first bit of a word uses the live direction input; later bits
        // use the direction latched with that first bit.
        dir_w   = start_w ? msb_first : dir_q;
        // A new word shifts into a cleared register so no stale bits remain.
        base_w  = start_w ? '0 : sr_q;
        if (dir_w) begin
            sr_d = {base_w[WIDTH-2:0], s_in};
        end else begin
            sr_d = {s_in, base_w[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            d_out_q     <= '0;
            d_valid_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= start_w & (state_q == S_RECV);

            if (start_w) begin
                sr_q    <= sr_d;
                dir_q   <= msb_first;
                cnt_q   <= CNT_W'(1);
                state_q <= S_RECV;
            end else if (take_w) begin
                sr_q <= sr_d;
                if (last_w) begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            // A completing word loads if the holding register is empty or
            // being consumed on this same edge; otherwise it is dropped.
            if (last_w && (!d_valid_q || d_ready)) begin
                d_out_q   <= sr_d;
                d_valid_q <= 1'b1;
            end else if (d_valid_q && d_ready) begin
                d_valid_q <= 1'b0;
            end

            // Setting has priority over clearing.
            if (last_w && d_valid_q && !d_ready) begin
                overrun_q <= 1'b1;
            end else if (ovr_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign d_out     = d_out_q;
    assign d_valid   = d_valid_q;
    assign busy      = (state_q == S_RECV);
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_rx_8.sv
`default_nettype none
//============================================================================
// Module   : tb_shift_rx_8
// Purpose  : Self-checking bench for shift_rx_8. A bit-list reference model
//            pushes every word expected in the holding register into a
//            scoreboard queue; a negedge monitor pops and compares whenever a
//            new word is presented, and checks status flags each cycle.
// Revision : 1.0 - initial release
//============================================================================
module tb_shift_rx_8;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_in, shift, frame, msb_first, d_ready, ovr_clr;
    logic [W-1:0] d_out;
    logic         d_valid, busy, overrun, frame_err;

    int checks = 0;
    int errors = 0;

    shift_rx_8 #(.WIDTH(W), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_in      (s_in),
        .shift     (shift),
        .frame     (frame),
        .msb_first (msb_first),
        .d_ready   (d_ready),
        .ovr_clr   (ovr_clr),
        .d_out     (d_out),
        .d_valid   (d_valid),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the word in progress is a list of received bits.
    // ------------------------------------------------------------------
    bit       bits[$];
    bit       dir_m;
    bit       vld_m, ovr_m, ferr_m;
    int       sbq[$];

    function automatic int assemble(input bit msb);
        int w = 0;
        for (int i = 0; i < W; i++) begin
            if (msb) w = w + (int'(bits[i]) << (W - 1 - i));
            else     w = w + (int'(bits[i]) << i);
        end
        return w;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bits.delete();
            sbq.delete();
            vld_m  = 1'b0;
            ovr_m  = 1'b0;
            ferr_m = 1'b0;
            dir_m  = 1'b0;
        end else begin
            bit consume, load, set_ovr;
            consume = vld_m && d_ready;
            load    = 1'b0;
            set_ovr = 1'b0;
            ferr_m  = 1'b0;
            if (shift) begin
                if (frame) begin
                    if (bits.size() > 0) ferr_m = 1'b1;
                    bits.delete();
                    dir_m = msb_first;
                    bits.push_back(s_in);
                end else if (bits.size() > 0) begin
                    bits.push_back(s_in);
                    if (bits.size() == W) begin
                        int w;
                        w = assemble(dir_m);
                        bits.delete();
                        if (!vld_m || d_ready) begin
                            load = 1'b1;
                            sbq.push_back(w);
                        end else begin
                            set_ovr = 1'b1;
                        end
                    end
                end
            end
            if (load)         vld_m = 1'b1;
            else if (consume) vld_m = 1'b0;
            if (set_ovr)      ovr_m = 1'b1;
            else if (ovr_clr) ovr_m = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: compares flags every cycle and pops on each new presentation.
    // ------------------------------------------------------------------
    bit fresh = 1'b1;
    int last_word = 0;

    always @(negedge clk) begin
        if (rst) begin
            fresh = 1'b1;
        end else begin
            chk("busy", int'(busy), int'(bits.size() > 0));
            chk("d_valid", int'(d_valid), int'(vld_m));
            chk("overrun", int'(overrun), int'(ovr_m));
            chk("frame_err", int'(frame_err), int'(ferr_m));
            if (d_valid) begin
                if (fresh) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL word: got 0x%0h but no word expected at %0t", d_out, $time);
                    end else begin
                        last_word = sbq.pop_front();
                        chk("word", int'(d_out), last_word);
                    end
                end else begin
                    chk("hold", int'(d_out), last_word);
                end
            end
            fresh = !d_valid || d_ready;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        shift = 1'b0;
        frame = 1'b0;
        s_in  = 1'b0;
    endtask

    // Sends a framed word on consecutive strobes; optionally raises d_ready
    // together with the last bit.
    task automatic send_word(input logic [7:0] w, input bit msb, input bit rdy_last);
        msb_first = msb;
        for (int i = 0; i < W; i++) begin
            shift = 1'b1;
            frame = (i == 0);
            s_in  = msb ? w[W-1-i] : w[i];
            if (i == W - 1 && rdy_last) d_ready = 1'b1;
            step();
        end
        idle_in();
    endtask

    task automatic consume_one();
        d_ready = 1'b1;
        step();
        d_ready = 1'b0;
        chk("consumed_valid", int'(d_valid), 0);
    endtask

    initial begin
        logic [7:0] t2_bits;
        rst = 1'b1;
        idle_in();
        msb_first = 1'b1;
        d_ready   = 1'b0;
        ovr_clr   = 1'b0;
        step();
        step();
        chk("rst_d_out", int'(d_out), 0);
        chk("rst_d_valid", int'(d_valid), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        step();

        // 1: MSB-first 0,1,0,1,0,1,0,1 -> 0x55
        send_word(8'h55, 1'b1, 1'b0);
        chk("t1_d_out", int'(d_out), 'h55);
        chk("t1_d_valid", int'(d_valid), 1);
        chk("t1_busy", int'(busy), 0);
        consume_one();

        // 2: LSB-first 1,0,1,0 | gap of 3 | 0,0,0,0 with msb_first toggling -> 0x05
        t2_bits = 8'b0000_0101;
        msb_first = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i == 4) begin
                idle_in();
                repeat (3) step();
                chk("t2_busy_gap", int'(busy), 1);
            end
            shift = 1'b1;
            frame = (i == 0);
            s_in  = t2_bits[i];
            if (i > 0) msb_first = ~msb_first;
            step();
        end
        idle_in();
        chk("t2_d_out", int'(d_out), 'h05);
        consume_one();

        // 3: overrun while holding 0xA5
        send_word(8'hA5, 1'b1, 1'b0);
        send_word(8'h3C, 1'b1, 1'b0);
        chk("t3_d_out", int'(d_out), 'hA5);
        chk("t3_overrun", int'(overrun), 1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("t3_ovr_clr", int'(overrun), 0);
        consume_one();

        // 4: consume and completion on the same edge
        send_word(8'h11, 1'b1, 1'b0);
        send_word(8'h22, 1'b1, 1'b1);
        chk("t4_d_out", int'(d_out), 'h22);
        chk("t4_d_valid", int'(d_valid), 1);
        chk("t4_overrun", int'(overrun), 0);
        step();
        d_ready = 1'b0;
        chk("t4_consumed", int'(d_valid), 0);

        // 5: resync after 5 bits, then 1,1,1,1,0,0,0,0 -> 0xF0
        msb_first = 1'b1;
        for (int i = 0; i < 5; i++) begin
            shift = 1'b1;
            frame = (i == 0);
            s_in  = 1'($urandom_range(0, 1));
            step();
        end
        send_word(8'hF0, 1'b1, 1'b0);
        chk("t5_d_out", int'(d_out), 'hF0);
        // frame_err pulsed on the edge of the resync strobe; re-run a
        // resync to observe the pulse directly.
        for (int i = 0; i < 3; i++) begin
            shift = 1'b1;
            frame = (i == 0);
            s_in  = 1'b1;
            step();
        end
        frame = 1'b1;
        step();
        frame = 1'b0;
        chk("t5_frame_err", int'(frame_err), 1);
        step();
        chk("t5_frame_err_off", int'(frame_err), 0);
        idle_in();

        // 6: async reset mid-word while a word is still held
        send_word(8'h0F, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            shift = 1'b1;
            frame = (i == 0);
            s_in  = 1'b1;
            step();
        end
        idle_in();
        rst = 1'b1;
        #1;
        chk("t6_d_out", int'(d_out), 0);
        chk("t6_d_valid", int'(d_valid), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_overrun", int'(overrun), 0);
        step();
        rst = 1'b0;
        shift = 1'b1;
        s_in  = 1'b1;
        repeat (3) step();
        idle_in();
        chk("t6_ignored", int'(busy), 0);
        send_word(8'h81, 1'b1, 1'b0);
        chk("t6_d_out_81", int'(d_out), 'h81);
        consume_one();

        // Randomised traffic
        for (int c = 0; c < 1500; c++) begin
            shift     = ($urandom_range(0, 3) != 0);
            frame     = ($urandom_range(0, 9) == 0);
            s_in      = 1'($urandom_range(0, 1));
            msb_first = 1'($urandom_range(0, 1));
            d_ready   = 1'($urandom_range(0, 1));
            ovr_clr   = ($urandom_range(0, 15) == 0);
            step();
        end
        idle_in();
        ovr_clr = 1'b0;
        d_ready = 1'b1;
        repeat (4) step();
        chk("drain_queue", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_rx_8.md
Name: shift_rx_8

Overview:
Serial-in/parallel-out receiver: the opposite end of the team's 8-bit load/shift register, which serialises bytes.
- Samples one serial bit per shift strobe, framed by a start-of-word marker.
- Assembles WIDTH bits MSB-first or LSB-first.
- Presents each completed word on a valid/ready output holding register, with overrun and framing-error reporting.

Parameters:
WIDTH, 8, word length in bits (>=2).
CNT_W, 3, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
s_in  input  1  serial data bit, valid when shift is high.
shift  input  1  bit strobe; one bit is sampled per cycle while high.
frame  input  1  marks the current strobed bit as bit 0 of a new word (only meaningful with shift=1).
msb_first  input  1  1: first received bit lands in d_out[WIDTH-1]; 0: first bit lands in d_out[0].
d_ready  input  1  consumer accepts d_out when d_valid=1.
ovr_clr  input  1  clears the sticky overrun flag.
d_out  output  WIDTH  received word (holding register).
d_valid  output  1  d_out holds an unconsumed word.
busy  output  1  a word is in progress (state RECV).
overrun  output  1  sticky: a completed word was dropped because the holding register was full.
frame_err  output  1  one-cycle pulse: frame arrived mid-word.

Behaviour:
- Reset (async, rst=1):
  - State IDLE; shift register, bit counter and latched direction cleared.
  - d_out=0, d_valid=0, busy=0, overrun=0, frame_err=0.
  - Reset mid-word discards the partial word.
- States: IDLE, RECV.
- IDLE:
  - shift=1 with frame=1 captures s_in as bit 0, latches msb_first for the whole word, sets cnt=1, goes to RECV.
  - shift=1 with frame=0 is ignored.
- RECV:
  - Each shift=1 with frame=0 captures s_in and increments cnt. shift=0 holds all state; gaps of any length are allowed.
  - msb_first changes during RECV are ignored until the next word.
- Shift rule:
  - MSB-first: sr <= {sr[WIDTH-2:0], s_in}.
  - LSB-first: sr <= {s_in, sr[WIDTH-1:1]}.
- Word completion: the strobe that captures the WIDTH-th bit (cnt==WIDTH-1) completes the word.
  - The assembled word, including that bit, is written to d_out on the same edge.
  - d_valid=1 from the next cycle; state returns to IDLE, cnt=0.
  - Latency: d_out/d_valid are visible one cycle after the last bit's strobe edge.
- Resync: frame=1 with shift=1 while in RECV (cnt>=1):
  - The partial word is discarded and the current bit becomes bit 0 of a new word (cnt=1, direction relatched).
  - frame_err pulses high for exactly one cycle.
- Handshake:
  - d_valid && d_ready on an edge consumes the word; d_valid falls next cycle unless a new word completes on the same edge.
  - Simultaneous consume + completion: the new word loads, d_valid stays 1, no overrun.
  - Completion while d_valid=1 and d_ready=0: the new word is dropped, d_out keeps the old word, overrun is set.
- overrun stays set until ovr_clr=1. If ovr_clr and a new overrun occur on the same edge, overrun stays 1 (set wins).
- d_out is stable while d_valid=1 and not consumed.
- busy = (state==RECV).

Test Plan:
1. Reset, then msb_first=1, frame on first strobe, strobes s_in=0,1,0,1,0,1,0,1 on consecutive cycles -> d_out=0x55 and d_valid=1 the cycle after the 8th strobe; busy=1 during bits 2-8. With d_ready=1, d_valid drops the following cycle.
2. msb_first=0, bits 1,0,1,0,0,0,0,0, with shift deasserted for 3 cycles between bits 4 and 5 -> d_out=0x05; msb_first toggled mid-word has no effect.
3. d_ready=0; receive 0xA5 then 0x3C -> d_out stays 0xA5, overrun=1. Pulse ovr_clr -> overrun=0; d_ready=1 -> d_valid falls.
4. Hold d_valid with 0x11; time d_ready=1 on the same edge as the last bit of 0x22 -> d_out=0x22, d_valid stays 1, overrun=0.
5. After 5 bits, assert frame with shift -> frame_err=1 for one cycle; the next 8 bits 1,1,1,1,0,0,0,0 (msb_first=1) -> d_out=0xF0.
6. Assert rst after 4 bits of a word -> all outputs 0 immediately (async). Strobes without frame are ignored; a fresh framed word 0x81 is received correctly.
